// File: rtl/uart_pin_host.sv
// Host-side pin sequencer for the UART tapeout wrapper: turns single-cycle
// commands into direction/rate/data pin sequences and samples the chip's rx bus.
module uart_pin_host #(
    parameter int SampleDelay = 3,
    parameter int GapCycles   = 2
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [1:0] cmd_rate,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_empty,
    output logic [3:0] control,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    input  logic       err_in,
    input  logic       rts_in,
    output logic       err_sync,
    output logic       rts_sync,
    output logic       bad_cmd
);

    typedef enum logic [2:0] {
        IDLE,
        DIR,
        RELEASE,
        HOLD,
        WAIT,
        GAP
    } state_t;

    localparam logic [1:0] OP_RATE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // WAIT covers cycles 3 .. 1+SampleDelay, so the counter runs SampleDelay-2 down to 0.
    localparam logic [3:0] WAIT_LAST = 4'(SampleDelay - 2);
    localparam logic [3:0] GAP_LAST  = 4'(GapCycles - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [1:0] op_reg;
    logic [7:0] data_reg;
    logic [1:0] rate_reg;
    logic       bad_reg;
    logic       rsp_valid_reg;
    logic [7:0] rsp_data_reg;
    logic       rsp_empty_reg;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;

    logic       accept;
    logic       capture;
    logic [1:0] dir_code;

    assign accept  = cmd_valid && (state_reg == IDLE);
    assign capture = (state_reg == WAIT) && (cnt_reg == 4'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: if (cmd_data != 8'h00) state_next = DIR;
                        OP_READ:  state_next = DIR;
                        OP_CLEAR: state_next = DIR;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            DIR: state_next = RELEASE;
            RELEASE: begin
                case (op_reg)
                    OP_WRITE: state_next = HOLD;
                    OP_READ: begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LAST;
                    end
                    default: begin
                        state_next = GAP;
                        cnt_next   = GAP_LAST;
                    end
                endcase
            end
            HOLD: begin
                state_next = GAP;
                cnt_next   = GAP_LAST;
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LAST;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            GAP: begin
                if (cnt_reg == 4'd0) state_next = IDLE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Direction code is asserted only in DIR, so it can never stay nonzero for two cycles.
    always_comb begin
        dir_code = 2'b00;
        if (state_reg == DIR) begin
            case (op_reg)
                OP_WRITE: dir_code = 2'b01;
                OP_READ:  dir_code = 2'b10;
                OP_CLEAR: dir_code = 2'b11;
                default:  dir_code = 2'b00;
            endcase
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (op_reg == OP_WRITE &&
            (state_reg == DIR || state_reg == RELEASE || state_reg == HOLD)) begin
            tx_data = data_reg;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_reg        <= OP_RATE;
            data_reg      <= 8'h00;
            rate_reg      <= 2'b00;
            bad_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'h00;
            rsp_empty_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= capture;
            if (accept) begin
                op_reg   <= cmd_op;
                data_reg <= cmd_data;
                if (cmd_op == OP_RATE) rate_reg <= cmd_rate;
                if (cmd_op == OP_WRITE && cmd_data == 8'h00) bad_reg <= 1'b1;
                if (cmd_op == OP_CLEAR) bad_reg <= 1'b0;
            end
            if (capture) begin
                rsp_data_reg  <= rx_data;
                rsp_empty_reg <= (rx_data == 8'h00);
            end
        end
    end

    // Two-flop synchronizers for the chip's asynchronous status pins: {rts, err}.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta_reg <= 2'b00;
            sync_reg <= 2'b00;
        end else begin
            meta_reg <= {rts_in, err_in};
            sync_reg <= meta_reg;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign control   = {dir_code, rate_reg};
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_empty = rsp_empty_reg;
    assign bad_cmd   = bad_reg;
    assign err_sync  = sync_reg[0];
    assign rts_sync  = sync_reg[1];

endmodule
